mac_pe_param: RTL and testbench

MAC_PE_PARAM -- requirements
Module: mac_pe_param

---
 rtl/mac_pe_param.sv | 129 ++++++++++++
 tb/tb_mac_pe_param.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/mac_pe_param.sv
// Weight-stationary MAC processing element for a systolic array.
// Double-buffered weights stream down the chain while data flows east/south.
module mac_pe_param #(
  parameter int DATA_W   = 8,
  parameter int WEIGHT_W = 8,
  parameter int ACC_W    = 20,
  parameter int SATURATE = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                w_load,
  input  logic [WEIGHT_W-1:0] w_in,
  input  logic                w_swap,
  output logic [WEIGHT_W-1:0] w_out,
  output logic                shadow_vld,
  input  logic                in_valid,
  input  logic [DATA_W-1:0]   a_in,
  input  logic [ACC_W-1:0]    psum_in,
  output logic [DATA_W-1:0]   a_out,
  output logic [ACC_W-1:0]    psum_out,
  output logic                out_valid,
  output logic                ovf,
  input  logic                clr_ovf
);

  localparam int PROD_W = DATA_W + WEIGHT_W;

  localparam logic [ACC_W-1:0] MAX_V =
    {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] MIN_V =
    {1'b1, {(ACC_W-1){1'b0}}};

  if (ACC_W < PROD_W) begin : g_acc_w_chk
    $error("mac_pe_param: ACC_W narrower than product");
  end

  logic [WEIGHT_W-1:0] shadow_q, shadow_d;
  logic [WEIGHT_W-1:0] active_q, active_d;
  logic                svld_q, svld_d;
  logic [DATA_W-1:0]   a_q, a_d;
  logic [ACC_W-1:0]    psum_q, psum_d;
  logic                vld_q, vld_d;
  logic                ovf_q, ovf_d;

  logic signed [DATA_W-1:0]   a_s;
  logic signed [WEIGHT_W-1:0] w_s;
  logic signed [PROD_W-1:0]   prod;
  logic signed [ACC_W-1:0]    prod_ext;
  logic [ACC_W-1:0]           sum;
  logic                       ovf_hit;
  logic [ACC_W-1:0]           result;

  // Weight double buffer: a swap commits the old shadow even
  // when a new load lands in the same cycle.
  always_comb begin
    shadow_d = shadow_q;
    active_d = active_q;
    svld_d   = svld_q;
    if (w_swap && svld_q) begin
      active_d = shadow_q;
      svld_d   = 1'b0;
    end
    if (w_load) begin
      shadow_d = w_in;
      svld_d   = 1'b1;
    end
  end

  always_comb begin
    a_s      = $signed(a_in);
    w_s      = $signed(active_q);
    prod     = PROD_W'(a_s) * PROD_W'(w_s);
    prod_ext = ACC_W'(prod);
    sum      = psum_in + prod_ext;
    ovf_hit  = (psum_in[ACC_W-1] == prod_ext[ACC_W-1]) &&
               (sum[ACC_W-1] != psum_in[ACC_W-1]);
    result   = sum;
    if (SATURATE != 0 && ovf_hit) begin
      result = psum_in[ACC_W-1] ? MIN_V : MAX_V;
    end
  end

  always_comb begin
    a_d    = a_q;
    psum_d = psum_q;
    vld_d  = 1'b0;
    ovf_d  = ovf_q;
    if (in_valid) begin
      a_d    = a_in;
      psum_d = result;
      vld_d  = 1'b1;
    end
    // A fresh overflow outranks a clear in the same cycle.
    if (clr_ovf) begin
      ovf_d = 1'b0;
    end
    if (in_valid && ovf_hit) begin
      ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_q <= '0;
      active_q <= '0;
      svld_q   <= 1'b0;
      a_q      <= '0;
      psum_q   <= '0;
      vld_q    <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      shadow_q <= shadow_d;
      active_q <= active_d;
      svld_q   <= svld_d;
      a_q      <= a_d;
      psum_q   <= psum_d;
      vld_q    <= vld_d;
      ovf_q    <= ovf_d;
    end
  end

  assign w_out      = shadow_q;
  assign shadow_vld = svld_q;
  assign a_out      = a_q;
  assign psum_out   = psum_q;
  assign out_valid  = vld_q;
  assign ovf        = ovf_q;

endmodule

// File: tb/tb_mac_pe_param.sv
// Bench for mac_pe_param: wrapping and saturating instances side by side,
// checked every cycle against an integer-arithmetic model.
module tb_mac_pe_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst, w_load, w_swap, in_valid, clr_ovf;
  logic signed [7:0]  w_in, a_in;
  logic signed [15:0] psum_in;

  logic signed [7:0]  w_out_w, w_out_s, a_out_w, a_out_s;
  logic signed [15:0] psum_w, psum_s;
  logic svld_w, svld_s, vld_w, vld_s, ovf_w, ovf_s;

  mac_pe_param #(.DATA_W(8), .WEIGHT_W(8), .ACC_W(16), .SATURATE(0)) u_wrap (
    .clk(clk), .rst(rst), .w_load(w_load), .w_in(w_in), .w_swap(w_swap),
    .w_out(w_out_w), .shadow_vld(svld_w), .in_valid(in_valid),
    .a_in(a_in), .psum_in(psum_in), .a_out(a_out_w), .psum_out(psum_w),
    .out_valid(vld_w), .ovf(ovf_w), .clr_ovf(clr_ovf)
  );

  mac_pe_param #(.DATA_W(8), .WEIGHT_W(8), .ACC_W(16), .SATURATE(1)) u_sat (
    .clk(clk), .rst(rst), .w_load(w_load), .w_in(w_in), .w_swap(w_swap),
    .w_out(w_out_s), .shadow_vld(svld_s), .in_valid(in_valid),
    .a_in(a_in), .psum_in(psum_in), .a_out(a_out_s), .psum_out(psum_s),
    .out_valid(vld_s), .ovf(ovf_s), .clr_ovf(clr_ovf)
  );

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  // model state, plain integers
  int m_shadow, m_active, m_a, m_pw, m_ps;
  bit m_svld, m_vld, m_ovf;

  task automatic chk(input string nm, input logic signed [31:0] act,
                     input logic signed [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_step();
    int full, wr, old_active;
    bit ovfl;
    if (rst) begin
      m_shadow = 0; m_active = 0; m_svld = 0;
      m_a = 0; m_pw = 0; m_ps = 0; m_vld = 0; m_ovf = 0;
      return;
    end
    old_active = m_active;
    if (w_swap && m_svld) begin
      m_active = m_shadow;
      m_svld   = 0;
    end
    if (w_load) begin
      m_shadow = int'(w_in);
      m_svld   = 1;
    end
    ovfl = 0;
    if (in_valid) begin
      full = int'(psum_in) + int'(a_in) * old_active;
      ovfl = (full > 32767) || (full < -32768);
      wr = full & 32'hFFFF;
      if (wr >= 32768) wr -= 65536;
      m_pw  = wr;
      m_ps  = (full > 32767) ? 32767 : (full < -32768) ? -32768 : full;
      m_a   = int'(a_in);
      m_vld = 1;
    end else begin
      m_vld = 0;
    end
    if (ovfl) m_ovf = 1;
    else if (clr_ovf) m_ovf = 0;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("w_out_wrap", w_out_w, m_shadow);
      chk("w_out_sat", w_out_s, m_shadow);
      chk("svld_wrap", svld_w, m_svld);
      chk("svld_sat", svld_s, m_svld);
      chk("a_out_wrap", a_out_w, m_a);
      chk("a_out_sat", a_out_s, m_a);
      chk("psum_wrap", psum_w, m_pw);
      chk("psum_sat", psum_s, m_ps);
      chk("vld_wrap", vld_w, m_vld);
      chk("vld_sat", vld_s, m_vld);
      chk("ovf_wrap", ovf_w, m_ovf);
      chk("ovf_sat", ovf_s, m_ovf);
    end
  end

  task automatic cyc(input logic r, input logic wl, input logic signed [7:0] wi,
                     input logic ws, input logic iv, input logic signed [7:0] a,
                     input logic signed [15:0] ps, input logic clr);
    rst = r; w_load = wl; w_in = wi; w_swap = ws;
    in_valid = iv; a_in = a; psum_in = ps; clr_ovf = clr;
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic idle();
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    rst = 1; w_load = 0; w_in = 0; w_swap = 0;
    in_valid = 0; a_in = 0; psum_in = 0; clr_ovf = 0;
    @(negedge clk);
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
    chk_en = 1'b1;
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
    chk("rst_psum", psum_w, 0);
    chk("rst_vld", vld_w, 0);
    chk("rst_svld", svld_w, 0);

    // reset then stream, active weight still 0
    cyc(0, 0, 0, 0, 1, 5, 7, 0);
    chk("first_psum", psum_w, 7);
    chk("first_vld", vld_w, 1);
    chk("first_ovf", ovf_w, 0);
    idle();
    chk("hold_psum", psum_w, 7);
    chk("hold_vld", vld_w, 0);

    // load -3, swap, stream
    cyc(0, 1, -3, 0, 0, 0, 0, 0);
    chk("load_wout", w_out_w, -3);
    chk("load_svld", svld_w, 1);
    cyc(0, 0, 0, 1, 0, 0, 0, 0);
    chk("swap_svld", svld_w, 0);
    cyc(0, 0, 0, 0, 1, 4, 10, 0);
    chk("neg_w_psum", psum_w, -2);

    // swap on the same edge as a beat
    cyc(0, 1, 2, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 0, 0, 0);
    cyc(0, 1, 6, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 1, 1, 0, 0);
    chk("midswap_old", psum_w, 2);
    cyc(0, 0, 0, 0, 1, 1, 0, 0);
    chk("midswap_new", psum_w, 6);

    // overflow: wrap vs clamp
    cyc(0, 1, 1, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 1, 16'sd32767, 0);
    chk("sat_psum", psum_s, 32767);
    chk("wrap_psum", psum_w, -32768);
    chk("sat_ovf", ovf_s, 1);
    chk("wrap_ovf", ovf_w, 1);

    // set beats clear, then a lone clear
    cyc(0, 0, 0, 0, 1, 1, 16'sd32767, 1);
    chk("ovf_set_wins", ovf_w, 1);
    cyc(0, 0, 0, 0, 0, 0, 0, 1);
    chk("ovf_cleared", ovf_w, 0);

    // reset mid-operation discards beat and pending shadow
    cyc(0, 1, 5, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 1, 3, 100, 0);
    chk("midrst_vld", vld_w, 0);
    chk("midrst_psum", psum_w, 0);
    chk("midrst_svld", svld_w, 0);
    chk("midrst_wout", w_out_w, 0);
    cyc(0, 0, 0, 1, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 3, 4, 0);
    chk("midrst_active0", psum_w, 4);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      logic signed [15:0] ps;
      ps = 16'($urandom);
      if ($urandom_range(0, 3) == 0)
        ps = ps[15] ? 16'sh8000 + 16'($urandom_range(0, 300))
                    : 16'sh7FFF - 16'($urandom_range(0, 300));
      cyc(($urandom_range(0, 63) == 0),
          ($urandom_range(0, 3) == 0), 8'($urandom),
          ($urandom_range(0, 3) == 0),
          ($urandom_range(0, 3) != 0), 8'($urandom),
          ps, ($urandom_range(0, 7) == 0));
    end

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
